bitplane_weight_serializer: RTL

- Producer side of the 16-lane bit-serial MAC datapath.
- Accepts one vector of VEC_LENGTH signed two's-complement weights per handshake and converts it to sign-magnitude.
- Streams one bit-plane column per beat: per-lane sign, per-lane w_bit, column_idx, plus load_accum on the first beat.
- Zero-skipping: bit-plane columns whose bit is 0 in every lane are never emitted, so a MAC consuming the stream spends cycles only on non-empty columns.

---
 rtl/bitplane_weight_serializer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bitplane_weight_serializer.sv
// -----------------------------------------------------------------------------
// bitplane_weight_serializer
//
// Producer side of the bit-serial MAC datapath. A vector of VEC_LENGTH signed
// two's-complement weights is captured in one handshake and converted to
// sign-magnitude. The magnitudes are then streamed one bit-plane column per
// beat, most significant column first. With SKIP_ZERO set, columns in which no
// lane has a 1 are never emitted. An all-zero vector still produces one beat
// (column 0, all bits 0) so the consumer always sees a last beat.
//
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   w_valid      input vector valid
//   w_ready      block accepts a vector this cycle (combinational from
//                out_ready when the final beat is being accepted)
//   w_in         VEC_LENGTH signed weights
//   first_in     vector starts a new accumulation (sampled with w_in)
//   out_valid    current beat valid
//   out_ready    consumer accepts the beat
//   sign         per-lane sign (1 = negative)
//   w_bit        per-lane magnitude bit at column_idx
//   column_idx   bit position of the current plane
//   load_accum   first beat of a first_in vector
//   last         final beat of the current vector
// All beat outputs are driven 0 while out_valid is 0.
// -----------------------------------------------------------------------------
module bitplane_weight_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 16,
    parameter int COL_W      = 3,
    parameter bit SKIP_ZERO  = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic signed [DATA_WIDTH-1:0] w_in [VEC_LENGTH],
    input  logic                         first_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [VEC_LENGTH-1:0]        sign,
    output logic [VEC_LENGTH-1:0]        w_bit,
    output logic [COL_W-1:0]             column_idx,
    output logic                         load_accum,
    output logic                         last
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Absolute value in DATA_WIDTH unsigned bits. The most negative weight
    // wraps to itself in two's complement, which read as unsigned is exactly
    // 2^(DATA_WIDTH-1), so no extra bit is needed.
    function automatic logic [DATA_WIDTH-1:0] abs_mag(input logic signed [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] neg;
        neg = (~w) + DATA_WIDTH'(1);
        abs_mag = w[DATA_WIDTH-1] ? neg : w;
    endfunction

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mag_q [VEC_LENGTH];
    logic [DATA_WIDTH-1:0]   mag_d [VEC_LENGTH];
    logic [VEC_LENGTH-1:0]   sign_q, sign_d;
    logic [DATA_WIDTH-1:0]   col_mask_q, col_mask_d;
    logic                    first_q, first_d;

    logic                    streaming;
    logic [DATA_WIDTH-1:0]   top_oh;
    logic [COL_W-1:0]        col_top;
    logic                    single;
    logic                    beat_acc;
    logic                    capture;
    logic [DATA_WIDTH-1:0]   new_mask;

    // Highest pending column, as both an index and a one-hot select. The
    // one-hot form is reused to pick each lane's bit and to retire the column.
    always_comb begin
        col_top = '0;
        top_oh  = '0;
        for (int c = 0; c < DATA_WIDTH; c++) begin
            if (col_mask_q[c]) begin
                col_top = COL_W'(c);
                top_oh  = DATA_WIDTH'(1) << c;
            end
        end
    end

    // Mask is never empty while streaming, so equality with the top one-hot
    // means exactly one column remains.
    assign single    = (col_mask_q == top_oh);
    assign streaming = (state_q == STREAM);
    assign beat_acc  = streaming & out_ready;
    assign w_ready   = ~streaming | (beat_acc & single);
    assign capture   = w_valid & w_ready;

    always_comb begin
        out_valid  = streaming;
        sign       = streaming ? sign_q : '0;
        column_idx = streaming ? col_top : '0;
        load_accum = streaming & first_q;
        last       = streaming & single;
        w_bit      = '0;
        for (int i = 0; i < VEC_LENGTH; i++) begin
            w_bit[i] = streaming & (|(mag_q[i] & top_oh));
        end
    end

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        sign_d     = sign_q;
        col_mask_d = col_mask_q;
        first_d    = first_q;
        new_mask   = '0;

        if (beat_acc) begin
            col_mask_d = col_mask_q & ~top_oh;
            first_d    = 1'b0;
            if (single) begin
                state_d = IDLE;
            end
        end

        // A capture in the same cycle as the final beat overrides the return
        // to IDLE, giving back-to-back vectors without a bubble.
        if (capture) begin
            for (int i = 0; i < VEC_LENGTH; i++) begin
                mag_d[i]  = abs_mag(w_in[i]);
                sign_d[i] = w_in[i][DATA_WIDTH-1];
                new_mask  = new_mask | mag_d[i];
            end
            if (!SKIP_ZERO) begin
                new_mask = '1;
            end
            if (new_mask == '0) begin
                new_mask = DATA_WIDTH'(1);
            end
            col_mask_d = new_mask;
            first_d    = first_in;
            state_d    = STREAM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mag_q      <= '{default: '0};
            sign_q     <= '0;
            col_mask_q <= '0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            sign_q     <= sign_d;
            col_mask_q <= col_mask_d;
            first_q    <= first_d;
        end
    end

endmodule
